// File: rtl/mem_port_arbiter.sv
// Arbitrates the byte-serial RAM controller port between i-cache fetch, MEM-stage load/store and
// (with MEM_ARB_PREFETCH_EN defined) an instruction prefetcher; one transaction in flight at a time.
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic [DATA_W-1:0] inst_rdata,
   output logic              inst_done,
   input  logic              data_req,
   input  logic              data_rw,
   input  logic [1:0]        data_type,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic [DATA_W-1:0] data_rdata,
   output logic              data_done,
`ifdef MEM_ARB_PREFETCH_EN
   input  logic              pf_req,
   input  logic [ADDR_W-1:0] pf_addr,
   output logic [DATA_W-1:0] pf_rdata,
   output logic              pf_done,
`endif
   output logic              port_valid,
   input  logic              port_ready,
   output logic              port_rw,
   output logic [1:0]        port_type,
   output logic [ADDR_W-1:0] port_addr,
   output logic [DATA_W-1:0] port_wdata,
   input  logic              port_done,
   input  logic [DATA_W-1:0] port_rdata,
   output logic [1:0]        owner
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   localparam logic [1:0] OWN_NONE  = 2'b00;
   localparam logic [1:0] OWN_INST  = 2'b01;
   localparam logic [1:0] OWN_DATA  = 2'b10;
   localparam logic [1:0] OWN_PF    = 2'b11;
   localparam logic [1:0] TYPE_WORD = 2'b10;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t           state;
   state_t           state_next;
   logic [1:0]       grant;
   logic [CNT_W-1:0] starve_cnt;
   logic             starve_hit;

   assign starve_hit = (starve_cnt == CNT_W'(STARVE_LIMIT));

   // Data normally wins; a starved fetch jumps ahead once the counter saturates.
   always_comb begin
      grant = OWN_NONE;
      if (inst_req && (starve_hit || !data_req)) begin
         grant = OWN_INST;
      end else if (data_req) begin
         grant = OWN_DATA;
`ifdef MEM_ARB_PREFETCH_EN
      end else if (pf_req) begin
         grant = OWN_PF;
`endif
      end

      state_next = state;
      case (state)
         IDLE:    if (grant != OWN_NONE) state_next = ISSUE;
         ISSUE:   if (port_valid && port_ready) state_next = WAIT;
         WAIT:    if (port_done) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner      <= OWN_NONE;
         port_valid <= 1'b0;
         port_rw    <= 1'b0;
         port_type  <= '0;
         port_addr  <= '0;
         port_wdata <= '0;
         inst_rdata <= '0;
         data_rdata <= '0;
         inst_done  <= 1'b0;
         data_done  <= 1'b0;
         starve_cnt <= '0;
`ifdef MEM_ARB_PREFETCH_EN
         pf_rdata   <= '0;
         pf_done    <= 1'b0;
`endif
      end else begin
         inst_done <= 1'b0;
         data_done <= 1'b0;
`ifdef MEM_ARB_PREFETCH_EN
         pf_done   <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (grant != OWN_NONE) begin
                  owner      <= grant;
                  port_valid <= 1'b1;
                  case (grant)
                     OWN_DATA: begin
                        port_rw    <= data_rw;
                        port_type  <= data_type;
                        port_addr  <= data_addr;
                        port_wdata <= data_wdata;
                     end
                     default: begin
                        port_rw    <= 1'b0;
                        port_type  <= TYPE_WORD;
                        port_wdata <= '0;
`ifdef MEM_ARB_PREFETCH_EN
                        port_addr  <= (grant == OWN_PF) ? pf_addr : inst_addr;
`else
                        port_addr  <= inst_addr;
`endif
                     end
                  endcase
                  if (grant == OWN_INST) begin
                     starve_cnt <= '0;
                  end else if (grant == OWN_DATA && inst_req && !starve_hit) begin
                     starve_cnt <= starve_cnt + CNT_W'(1);
                  end
               end
            end
            ISSUE: begin
               if (port_ready) port_valid <= 1'b0;
            end
            WAIT: begin
               if (port_done) begin
                  case (owner)
                     OWN_INST: begin
                        inst_rdata <= port_rdata;
                        inst_done  <= 1'b1;
                     end
                     OWN_DATA: begin
                        data_rdata <= port_rdata;
                        data_done  <= 1'b1;
                     end
`ifdef MEM_ARB_PREFETCH_EN
                     OWN_PF: begin
                        pf_rdata <= port_rdata;
                        pf_done  <= 1'b1;
                     end
`endif
                     default: ;
                  endcase
               end
            end
            RESP: begin
               owner <= OWN_NONE;
            end
            default: ;
         endcase
      end
   end

endmodule
